// File: rtl/l2_train_sched.sv
// Supervised-training scheduler for the L2 layer: opens a fixed training window per input
// event, scores label vs. winning spike, and counts samples/epochs until a stop condition.
module l2_train_sched #(
  parameter int unsigned P_EPOCHS     = 5000,
  parameter int unsigned P_SAMPLES    = 64,
  parameter int unsigned P_WINDOW     = 10,
  parameter int unsigned P_ACC_TARGET = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [1:0]  i_event,
  input  logic [3:0]  i_label,
  input  logic [3:0]  i_l2_spikeout,
  output logic        o_train_en,
  output logic        o_endof_epochs,
  output logic        o_busy,
  output logic        o_epoch_pulse,
  output logic [15:0] o_epoch,
  output logic [15:0] o_sample,
  output logic [15:0] o_hits
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_EVT,
    S_WINDOW,
    S_SCORE,
    S_EPOCH_END,
    S_DONE
  } state_t;

  localparam logic [15:0] EPOCHS_C   = 16'(P_EPOCHS);
  localparam logic [15:0] SAMPLES_C  = 16'(P_SAMPLES);
  localparam logic [15:0] ACC_C      = 16'(P_ACC_TARGET);
  localparam logic [7:0]  WIN_LAST_C = 8'(P_WINDOW - 1);

  state_t      state_q, state_d;
  logic [7:0]  win_cnt_q, win_cnt_d;
  logic [3:0]  label_q, label_d;
  logic        label_vld_q, label_vld_d;
  logic [3:0]  winner_q, winner_d;
  logic        winner_vld_q, winner_vld_d;
  logic [15:0] epoch_q, epoch_d;
  logic [15:0] sample_q, sample_d;
  logic [15:0] hits_q, hits_d;

  logic [15:0] sample_inc;
  logic [15:0] hits_inc;
  logic [15:0] epoch_inc;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    sample_inc = sat_inc(sample_q);
    hits_inc   = sat_inc(hits_q);
    epoch_inc  = sat_inc(epoch_q);
  end

  always_comb begin
    state_d      = state_q;
    win_cnt_d    = win_cnt_q;
    label_d      = label_q;
    label_vld_d  = label_vld_q;
    winner_d     = winner_q;
    winner_vld_d = winner_vld_q;
    epoch_d      = epoch_q;
    sample_d     = sample_q;
    hits_d       = hits_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          epoch_d  = 16'd0;
          sample_d = 16'd0;
          hits_d   = 16'd0;
          state_d  = S_WAIT_EVT;
        end
      end
      S_WAIT_EVT: begin
        if (|i_event) begin
          win_cnt_d    = 8'd0;
          label_d      = 4'd0;
          label_vld_d  = 1'b0;
          winner_d     = 4'd0;
          winner_vld_d = 1'b0;
          state_d      = S_WINDOW;
        end
      end
      S_WINDOW: begin
        // Only the first clean one-hot vector counts; later changes and multi-hot are ignored.
        if (!label_vld_q && $onehot(i_label)) begin
          label_d     = i_label;
          label_vld_d = 1'b1;
        end
        if (!winner_vld_q && $onehot(i_l2_spikeout)) begin
          winner_d     = i_l2_spikeout;
          winner_vld_d = 1'b1;
        end
        if (win_cnt_q == WIN_LAST_C) begin
          state_d = S_SCORE;
        end else begin
          win_cnt_d = win_cnt_q + 8'd1;
        end
      end
      S_SCORE: begin
        state_d = S_WAIT_EVT;
        if (label_vld_q) begin
          sample_d = sample_inc;
          if (winner_vld_q && (winner_q == label_q)) begin
            hits_d = hits_inc;
          end
          if (sample_inc == SAMPLES_C) begin
            state_d = S_EPOCH_END;
          end
        end
      end
      S_EPOCH_END: begin
        epoch_d = epoch_inc;
        if ((epoch_inc == EPOCHS_C) || ((P_ACC_TARGET != 0) && (hits_q >= ACC_C))) begin
          state_d = S_DONE;
        end else begin
          sample_d = 16'd0;
          hits_d   = 16'd0;
          state_d  = S_WAIT_EVT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort beats every transition and leaves the counters as they were.
    if (i_abort) begin
      state_d  = S_IDLE;
      epoch_d  = epoch_q;
      sample_d = sample_q;
      hits_d   = hits_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      win_cnt_q    <= 8'd0;
      label_q      <= 4'd0;
      label_vld_q  <= 1'b0;
      winner_q     <= 4'd0;
      winner_vld_q <= 1'b0;
      epoch_q      <= 16'd0;
      sample_q     <= 16'd0;
      hits_q       <= 16'd0;
    end else begin
      state_q      <= state_d;
      win_cnt_q    <= win_cnt_d;
      label_q      <= label_d;
      label_vld_q  <= label_vld_d;
      winner_q     <= winner_d;
      winner_vld_q <= winner_vld_d;
      epoch_q      <= epoch_d;
      sample_q     <= sample_d;
      hits_q       <= hits_d;
    end
  end

  // Outputs decode the registered state, so reset forces them low without a clock.
  assign o_train_en     = (state_q == S_WINDOW);
  assign o_endof_epochs = (state_q == S_DONE);
  assign o_busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_epoch_pulse  = (state_q == S_EPOCH_END);
  assign o_epoch        = epoch_q;
  assign o_sample       = sample_q;
  assign o_hits         = hits_q;

endmodule
